// File: rtl/nibble_add_scheduler_pkg.sv
// Shared types and helpers for the nibble-serial add scheduler.
// Operands wider than NAS_MAX_W bits are not supported by nib_sel.
package nas_pkg;

    localparam int NIB_W     = 4;
    localparam int NAS_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } nas_state_e;

    function automatic logic [NIB_W-1:0] nib_sel(input logic [NAS_MAX_W-1:0] vec,
                                                 input int unsigned idx);
        logic [NAS_MAX_W-1:0] sh;
        sh = vec >> (idx * NIB_W);
        return sh[NIB_W-1:0];
    endfunction

endpackage

// File: rtl/nibble_add_scheduler_if.sv
// Request/result bundle between the two operand sources and the scheduler.
interface nibble_add_scheduler_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         cin0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         cin1;
    logic         res_valid;
    logic         res_id;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         busy;

    modport master (
        output req_valid, a0, b0, cin0, a1, b1, cin1,
        input  req_ready, res_valid, res_id, res_sum, res_cout, busy
    );

    modport slave (
        input  req_valid, a0, b0, cin0, a1, b1, cin1,
        output req_ready, res_valid, res_id, res_sum, res_cout, busy
    );

endinterface

// File: rtl/nibble_add_scheduler_adder.sv
// Shared 4-bit carry-lookahead adder; outputs float when the active-low enable is high.
module nas_add4
    import nas_pkg::*;
(
    input  logic [NIB_W-1:0] a_i,
    input  logic [NIB_W-1:0] b_i,
    input  logic             cin_i,
    input  logic             en_n_i,
    output wire  [NIB_W-1:0] sum_o,
    output wire              cout_o
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o  = en_n_i ? {NIB_W{1'bz}} : (p ^ c[NIB_W-1:0]);
    assign cout_o = en_n_i ? 1'bz : c[NIB_W];

endmodule

// File: rtl/nibble_add_scheduler_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the loser on every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
            else                gnt_o = req_i;
        end
    end

    // A grant is only ever issued to a valid requester, so it doubles as the accept pulse.
    assign ptr_d = gnt_o[0] ? 1'b1 : (gnt_o[1] ? 1'b0 : ptr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/nibble_add_scheduler.sv
// Arbitrates two requesters onto one 4-bit adder and steps a W-bit add one
// nibble per cycle, LSB first, returning sum, carry-out and owner ID.
module nibble_add_scheduler
    import nas_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_add_scheduler_if.slave  bus
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    nas_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic [W-1:0]     sum_d;
    logic             carry_q;
    logic             owner_q;
    logic             res_valid_q;
    logic             res_id_q;
    logic [W-1:0]     res_sum_q;
    logic             res_cout_q;
    logic             busy_q;

    logic [1:0]       gnt;
    logic             accept;
    logic             add_en_n;
    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    wire  [NIB_W-1:0] add_sum;
    wire              add_cout;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (bus.req_valid),
        .en_i  (state_q == IDLE),
        .gnt_o (gnt)
    );

    assign bus.req_ready = gnt;
    assign accept        = |gnt;
    assign add_en_n      = (state_q != ADD);

    assign nib_a = nib_sel(NAS_MAX_W'(a_q), 32'(idx_q));
    assign nib_b = nib_sel(NAS_MAX_W'(b_q), 32'(idx_q));

    nas_add4 u_add (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .cin_i  (carry_q),
        .en_n_i (add_en_n),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        sum_d = sum_q;
        sum_d[idx_q * NIB_W +: NIB_W] = add_sum;
    end

    // The last ADD cycle loads the result registers directly so the strobe lands in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            owner_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q <= gnt[1];
                        a_q     <= gnt[1] ? bus.a1   : bus.a0;
                        b_q     <= gnt[1] ? bus.b1   : bus.b0;
                        carry_q <= gnt[1] ? bus.cin1 : bus.cin0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q   <= sum_d;
                    carry_q <= add_cout;
                    if (idx_q == IDX_LAST) begin
                        res_valid_q <= 1'b1;
                        res_sum_q   <= sum_d;
                        res_cout_q  <= add_cout;
                        res_id_q    <= owner_q;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.busy      = busy_q;

endmodule
